// File: rtl/hazard_detection_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit_pkg
//   Shared pipeline definitions used by the hazard detection unit and the
//   forwarding logic: hazard FSM state encoding, MIPS opcode constants and
//   the R-type funct value that launches a multi-cycle multiply/divide.
// -----------------------------------------------------------------------------
package hazard_detection_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        FLUSH    = 2'd2
    } hdu_state_e;

    localparam logic [5:0] OP_RTYPE     = 6'b000000;
    localparam logic [5:0] OP_LW        = 6'b100011;
    localparam logic [5:0] OP_SW        = 6'b101011;
    localparam logic [5:0] FUNCT_MULDIV = 6'b011000;

    // Instructions whose rt field is a source operand (R-type ALU ops and
    // stores); for everything else rt is a destination and cannot hazard.
    function automatic logic rt_is_source(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW);
    endfunction

    // Multi-cycle op detection; funct[1:0] selects mult/multu/div/divu and
    // is deliberately not compared.
    function automatic logic is_muldiv(input logic [5:0] opcode,
                                       input logic [3:0] funct_hi,
                                       input logic [3:0] mask_hi);
        return (opcode == OP_RTYPE) && (funct_hi == mask_hi);
    endfunction

endpackage

// File: rtl/hazard_stats_counter.sv
// -----------------------------------------------------------------------------
// hazard_stats_counter
//   Saturating event counter used for the optional pipeline statistics.
//   Ports:
//     clk     - rising-edge clock
//     rst_n_i - asynchronous active-low reset, clears the count
//     inc     - count this cycle
//     count   - current count, sticks at all-ones
// -----------------------------------------------------------------------------
module hazard_stats_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit
//   Decode-stage hazard control for a 5-stage MIPS pipeline. Detects load-use
//   hazards (one bubble), holds the front end while a multi-cycle mul/div
//   occupies EX, and flushes IF/ID on a taken branch (which also aborts any
//   running mul/div).
//
//   Parameters:
//     MUL_LAT           - total EX occupancy of a mul/div in cycles (2..15)
//     MULDIV_FUNCT_MASK - R-type funct launching a mul/div, funct[1:0] ignored
//   Ports:
//     clk             - rising-edge clock
//     rst_n_i         - asynchronous active-low reset
//     instruction     - instruction in IF/ID
//     ID_EX_MemRead_r - instruction in EX is a load
//     ID_EX_rt_r      - destination register of that load
//     branch_taken_i  - EX resolved a taken branch/jump this cycle
//     pc_write_o      - PC enable
//     IF_ID_write_o   - IF/ID enable
//     ID_EX_bubble_o  - zero ID/EX control signals
//     IF_ID_flush_o   - clear IF/ID
//     busy_o          - a multi-cycle op occupies EX
//     stall_cnt_o     - (HAZARD_STATS_EN) cycles with pc_write_o = 0
//     flush_cnt_o     - (HAZARD_STATS_EN) cycles with IF_ID_flush_o = 1
//
//   Build option: define HAZARD_STATS_EN to add the saturating statistics
//   counters and their output ports.
// -----------------------------------------------------------------------------
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int unsigned MUL_LAT           = 4,
    parameter logic [5:0]  MULDIV_FUNCT_MASK = FUNCT_MULDIV
) (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic [31:0] instruction,
    input  logic        ID_EX_MemRead_r,
    input  logic [4:0]  ID_EX_rt_r,
    input  logic        branch_taken_i,
    output logic        pc_write_o,
    output logic        IF_ID_write_o,
    output logic        ID_EX_bubble_o,
    output logic        IF_ID_flush_o,
    output logic        busy_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    // The issuing cycle counts towards MUL_LAT, so the hold lasts one less.
    localparam logic [3:0] MUL_START = 4'(MUL_LAT - 1);

    hdu_state_e state;
    logic [3:0] mul_cnt;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       load_use;
    logic       muldiv_start;
    logic       unused_instr_bits;

    assign opcode            = instruction[31:26];
    assign rs                = instruction[25:21];
    assign rt                = instruction[20:16];
    assign unused_instr_bits = ^{instruction[15:6], instruction[1:0]};

    // $0 is never a real dependency, so a load to $0 cannot stall.
    assign load_use = ID_EX_MemRead_r && (ID_EX_rt_r != 5'd0) &&
                      ((ID_EX_rt_r == rs) ||
                       (rt_is_source(opcode) && (ID_EX_rt_r == rt)));

    assign muldiv_start = is_muldiv(opcode, instruction[5:2],
                                    MULDIV_FUNCT_MASK[5:2]);

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= RUN;
            mul_cnt <= '0;
        end else if (branch_taken_i) begin
            // A taken branch wins everywhere and kills any running mul/div.
            state   <= FLUSH;
            mul_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (!load_use && muldiv_start) begin
                        state   <= MUL_BUSY;
                        mul_cnt <= MUL_START;
                    end
                end
                MUL_BUSY: begin
                    mul_cnt <= mul_cnt - 4'd1;
                    if (mul_cnt == 4'd1) begin
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    state <= RUN;
                end
                default: begin
                    state   <= RUN;
                    mul_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs depend on the current decode instruction, so they are
    // combinational: a load-use stall must take effect in the same cycle.
    always_comb begin
        pc_write_o     = 1'b1;
        IF_ID_write_o  = 1'b1;
        ID_EX_bubble_o = 1'b0;
        IF_ID_flush_o  = 1'b0;
        busy_o         = (state == MUL_BUSY);

        if (branch_taken_i) begin
            IF_ID_flush_o  = 1'b1;
            ID_EX_bubble_o = 1'b1;
        end else begin
            unique case (state)
                MUL_BUSY: begin
                    pc_write_o     = 1'b0;
                    IF_ID_write_o  = 1'b0;
                    ID_EX_bubble_o = 1'b1;
                end
                FLUSH: begin
                    IF_ID_flush_o = 1'b1;
                end
                default: begin
                    if (load_use) begin
                        pc_write_o     = 1'b0;
                        IF_ID_write_o  = 1'b0;
                        ID_EX_bubble_o = 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    hazard_stats_counter #(.CNT_W(32)) u_stall_cnt (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .inc     (~pc_write_o),
        .count   (stall_cnt_o)
    );

    hazard_stats_counter #(.CNT_W(32)) u_flush_cnt (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .inc     (IF_ID_flush_o),
        .count   (flush_cnt_o)
    );
`endif

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, meaning total EX occupancy in cycles of a multiply/divide (legal range 2..15).
REQ-002 SHALL have parameter MULDIV_FUNCT_MASK, default 6'b011000, meaning the R-type funct value that starts a multi-cycle op; the match ignores funct[1:0].
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have port instruction  input  32  instruction currently in IF/ID (decode stage).
REQ-006 SHALL have port ID_EX_MemRead_r  input  1  the instruction in EX is a load (opcode 6'b100011).
REQ-007 SHALL have port ID_EX_rt_r  input  5  destination register of the load in EX.
REQ-008 SHALL have port branch_taken_i  input  1  EX resolved a taken branch or jump this cycle.
REQ-009 SHALL have ports pc_write_o, IF_ID_write_o, ID_EX_bubble_o, IF_ID_flush_o  output  1 each  PC enable, IF/ID enable, zero ID/EX control, clear IF/ID.
REQ-010 SHALL have port busy_o  output  1  a multi-cycle op occupies EX.

Function
REQ-011 SHALL implement FSM states RUN, MUL_BUSY and FLUSH, with a 4-bit down-counter mul_cnt.
REQ-012 In RUN, a load-use hazard SHALL be ID_EX_MemRead_r=1 AND ID_EX_rt_r!=0 AND ID_EX_rt_r equals instruction[25:21], or equals instruction[20:16] when instruction[31:26] is 000000 or 101011.
REQ-013 A load-use hazard in RUN SHALL drive pc_write_o=0, IF_ID_write_o=0 and ID_EX_bubble_o=1 combinationally in the same cycle; the state SHALL stay RUN, giving exactly one bubble.
REQ-014 In RUN, a decode instruction with opcode 000000 and funct[5:2] matching MULDIV_FUNCT_MASK[5:2], and no hazard, SHALL move to MUL_BUSY with mul_cnt=MUL_LAT-1.
REQ-015 In MUL_BUSY, pc_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1 and busy_o=1; mul_cnt SHALL decrement each cycle; at mul_cnt==1 the next state SHALL be RUN.
REQ-016 branch_taken_i=1 in any state SHALL assert IF_ID_flush_o=1 and ID_EX_bubble_o=1 that cycle, force pc_write_o=1 and enter FLUSH.
REQ-017 Priority SHALL be branch_taken_i, then MUL_BUSY hold, then load-use, then multi-cycle start.
REQ-018 A branch during MUL_BUSY SHALL abort the op: mul_cnt cleared, busy_o=0 from the next cycle.
REQ-019 FLUSH SHALL last one cycle with IF_ID_flush_o=1 and pc_write_o=1, then return to RUN; branch_taken_i in FLUSH re-enters FLUSH.
REQ-020 Default outputs in RUN with no event SHALL be pc_write_o=1, IF_ID_write_o=1, all others 0.

Reset
REQ-021 rst_n_i=0 SHALL asynchronously force state RUN and mul_cnt=0; outputs SHALL then follow RUN defaults.
REQ-022 Reset asserted mid-MUL_BUSY or mid-FLUSH SHALL abandon the operation; the first cycle after release behaves as RUN.

Configuration
REQ-023 With HAZARD_STATS_EN defined, the block SHALL add outputs stall_cnt_o (32) and flush_cnt_o (32), counting cycles with pc_write_o=0 and cycles with IF_ID_flush_o=1; both saturate at all-ones and are cleared by reset.
REQ-024 Without HAZARD_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-025 The FSM state enum, opcode constants (LW 6'b100011, SW 6'b101011, RTYPE 6'b000000) and the MULDIV funct constant SHALL live in the shared pipeline package, which the forwarding logic also uses.
REQ-026 The optional statistics SHALL be one sub-module, hazard_stats_counter, instantiated twice.

Verification
REQ-027 Load-use: ID_EX_MemRead_r=1, ID_EX_rt_r=8, instruction add $9,$8,$10 -> exactly one cycle with pc_write_o=0 and ID_EX_bubble_o=1.
REQ-028 No false stall: ID_EX_rt_r=0 with instruction rs=0 -> pc_write_o stays 1; lw $8 in EX with addi using rt=8 as destination -> no stall.
REQ-029 Multi-cycle op: mult at MUL_LAT=4 -> busy_o=1 for exactly 3 cycles, then RUN.
REQ-030 Branch aborts multiply: branch_taken_i=1 in the 2nd MUL_BUSY cycle -> IF_ID_flush_o=1 for 2 cycles, then busy_o=0 and RUN.
REQ-031 Simultaneous events: branch_taken_i=1 together with a load-use hazard -> flush wins, pc_write_o=1, no stall.
REQ-032 Reset: rst_n_i pulsed low mid-MUL_BUSY, with no clock edge -> busy_o=0 immediately; with HAZARD_STATS_EN, stall_cnt_o=0.
